// File: rtl/banked_latch_file.sv
// Banked register file written by a synchronised, edge-detected push-button strobe.
// Optional debounce filter on the synchronised strobe: define BANKED_LATCH_FILE_DEBOUNCE_EN.
module banked_latch_file #(
    parameter int NUM_BANKS       = 4,
    parameter int DATA_W          = 8,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int SEL_W          = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_strobe,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic                 auto_mode,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [DATA_W-1:0]    rd_data,
    output logic [NUM_BANKS-1:0] bank_valid,
    output logic [SEL_W-1:0]     wr_ptr,
    output logic [CNT_W-1:0]     write_count
);

    logic                 s1_reg;
    logic                 s2_reg;
    logic                 prev_reg;
    logic                 level;
    logic                 we;
    logic                 wr_ok;
    logic [SEL_W-1:0]     target;
    logic [NUM_BANKS-1:0] wr_hit;
    logic [NUM_BANKS-1:0] rd_hit;
    logic [DATA_W-1:0]    rd_next;
    logic [DATA_W-1:0]    bank_reg [NUM_BANKS];

    // Two-flop synchroniser for the asynchronous button level, plus edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            s1_reg   <= wr_strobe;
            s2_reg   <= s1_reg;
            prev_reg <= level;
        end
    end

`ifdef BANKED_LATCH_FILE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_reg;
    logic            db_level_reg;

    // Level follows s2 only after it has disagreed for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
        end else if (s2_reg == db_level_reg) begin
            db_cnt_reg   <= '0;
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_reg   <= '0;
            db_level_reg <= s2_reg;
        end else begin
            db_cnt_reg   <= db_cnt_reg + 1'b1;
        end
    end

    assign level = db_level_reg;
`else
    assign level = s2_reg;
`endif

    assign we     = level & ~prev_reg;
    assign target = auto_mode ? wr_ptr : wr_sel;

    // One-hot decodes; an out-of-range select simply matches no bank.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_decode
            assign wr_hit[gi] = (target == SEL_W'(gi));
            assign rd_hit[gi] = (rd_sel == SEL_W'(gi));
        end
    endgenerate

    assign wr_ok = we & (|wr_hit);

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_hit[i]) begin
                rd_next = bank_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_reg[i] <= '0;
            end
            bank_valid  <= '0;
            wr_ptr      <= '0;
            write_count <= '0;
            rd_data     <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (we && wr_hit[i]) begin
                    bank_reg[i]   <= wr_data;
                    bank_valid[i] <= 1'b1;
                end
            end
            if (wr_ok && (write_count != '1)) begin
                write_count <= write_count + 1'b1;
            end
            // Explicit wrap so non-power-of-two depths never point past the last bank.
            if (we && auto_mode) begin
                wr_ptr <= (wr_ptr == SEL_W'(NUM_BANKS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_banked_latch_file.sv
// Directed bench: default 4-bank instance plus a 3-bank, 2-bit-counter instance on shared inputs.
module tb_banked_latch_file;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_strobe;
    logic       auto_mode;
    logic [7:0] wr_data;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;

    logic [7:0] rd_data_a;
    logic [3:0] bank_valid_a;
    logic [1:0] wr_ptr_a;
    logic [7:0] write_count_a;

    logic [7:0] rd_data_b;
    logic [2:0] bank_valid_b;
    logic [1:0] wr_ptr_b;
    logic [1:0] write_count_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    banked_latch_file u_dut_a (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .wr_sel(wr_sel), .auto_mode(auto_mode), .rd_sel(rd_sel),
        .rd_data(rd_data_a), .bank_valid(bank_valid_a), .wr_ptr(wr_ptr_a),
        .write_count(write_count_a)
    );

    banked_latch_file #(.NUM_BANKS(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .wr_sel(wr_sel), .auto_mode(auto_mode), .rd_sel(rd_sel),
        .rd_data(rd_data_b), .bank_valid(bank_valid_b), .wr_ptr(wr_ptr_b),
        .write_count(write_count_b)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] exp_ptr;
        logic [7:0] exp_cnt;
    } auto_vec_t;

    auto_vec_t  av_a [5];
    auto_vec_t  av_b [5];
    logic [7:0] exp_bank_a [4];
    logic [7:0] exp_bank_b [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Strobe high for 3 edges (write lands on the 3rd), then low long enough to re-arm.
    task automatic press(input logic [7:0] d, input logic am, input logic [1:0] sel);
        wr_data   = d;
        auto_mode = am;
        wr_sel    = sel;
        wr_strobe = 1'b1;
        repeat (3) step();
        wr_strobe = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        av_a[0] = '{8'h11, 2'd1, 8'd1};
        av_a[1] = '{8'h22, 2'd2, 8'd2};
        av_a[2] = '{8'h33, 2'd3, 8'd3};
        av_a[3] = '{8'h44, 2'd0, 8'd4};
        av_a[4] = '{8'h55, 2'd1, 8'd5};
        exp_bank_a = '{8'h55, 8'h22, 8'h33, 8'h44};

        av_b[0] = '{8'hA1, 2'd1, 8'd1};
        av_b[1] = '{8'hA2, 2'd2, 8'd2};
        av_b[2] = '{8'hA3, 2'd0, 8'd3};
        av_b[3] = '{8'hA4, 2'd1, 8'd3};
        av_b[4] = '{8'hA5, 2'd2, 8'd3};
        exp_bank_b = '{8'hA4, 8'hA5, 8'hA3};

        reset = 1'b1; wr_strobe = 1'b0; auto_mode = 1'b0;
        wr_data = 8'h00; wr_sel = 2'd0; rd_sel = 2'd0;
        step(); step();
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            step();
            check($sformatf("reset rd_data bank%0d", i), rd_data_a, 8'h00);
        end
        check("reset bank_valid", bank_valid_a, 4'b0000);
        check("reset write_count", write_count_a, 8'd0);
        check("reset wr_ptr", wr_ptr_a, 2'd0);

        // Direct write: exact 3-edge latency, single write for a held strobe, no read bypass
        wr_sel = 2'd2; wr_data = 8'hA5; auto_mode = 1'b0; rd_sel = 2'd2;
        wr_strobe = 1'b1;
        step();
        check("direct edge1 bank_valid", bank_valid_a, 4'b0000);
        step();
        check("direct edge2 write_count", write_count_a, 8'd0);
        step();
        check("direct edge3 bank_valid", bank_valid_a, 4'b0100);
        check("direct edge3 write_count", write_count_a, 8'd1);
        check("direct edge3 rd_data old", rd_data_a, 8'h00);
        step();
        check("direct edge4 rd_data new", rd_data_a, 8'hA5);
        repeat (6) step();
        check("direct held strobe count", write_count_a, 8'd1);
        check("direct wr_ptr holds", wr_ptr_a, 2'd0);
        wr_strobe = 1'b0;
        repeat (3) step();

        // Auto-increment mode
        do_reset();
        for (int k = 0; k < 5; k++) begin
            press(av_a[k].data, 1'b1, 2'd0);
            check($sformatf("auto press%0d wr_ptr", k), wr_ptr_a, av_a[k].exp_ptr);
            check($sformatf("auto press%0d write_count", k), write_count_a, av_a[k].exp_cnt);
        end
        auto_mode = 1'b0;
        step();
        check("auto_mode switch keeps wr_ptr", wr_ptr_a, 2'd1);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            step();
            check($sformatf("auto bank%0d", i), rd_data_a, exp_bank_a[i]);
        end
        check("auto bank_valid", bank_valid_a, 4'b1111);

        // Reset on the we cycle wins; strobe still high afterwards yields one write
        do_reset();
        wr_sel = 2'd1; wr_data = 8'h77; auto_mode = 1'b0; rd_sel = 2'd1;
        wr_strobe = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset-on-we bank_valid", bank_valid_a, 4'b0000);
        check("reset-on-we write_count", write_count_a, 8'd0);
        check("reset-on-we rd_data", rd_data_a, 8'h00);
        step(); step();
        check("post-reset no early write", write_count_a, 8'd0);
        step();
        check("post-reset single write count", write_count_a, 8'd1);
        check("post-reset single write valid", bank_valid_a, 4'b0010);
        step();
        check("post-reset rd_data", rd_data_a, 8'h77);
        wr_strobe = 1'b0;
        repeat (3) step();

        // Three-bank instance: out-of-range drop, wrap at 2, 2-bit saturation
        do_reset();
        press(8'h5A, 1'b0, 2'd3);
        check("b out-of-range write_count", write_count_b, 2'd0);
        check("b out-of-range bank_valid", bank_valid_b, 3'b000);
        rd_sel = 2'd3;
        step();
        check("b out-of-range rd_data", rd_data_b, 8'h00);
        for (int k = 0; k < 5; k++) begin
            press(av_b[k].data, 1'b1, 2'd0);
            check($sformatf("b auto press%0d wr_ptr", k), wr_ptr_b, av_b[k].exp_ptr);
            check($sformatf("b auto press%0d write_count", k), write_count_b, av_b[k].exp_cnt[1:0]);
        end
        for (int i = 0; i < 3; i++) begin
            rd_sel = 2'(i);
            step();
            check($sformatf("b bank%0d", i), rd_data_b, exp_bank_b[i]);
        end
        check("b bank_valid", bank_valid_b, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/banked_latch_file.md
Name: banked_latch_file

Overview:
- Clocked, parametrised successor to the 4×8 latch bank with demux write routing and mux readback.
- Holds NUM_BANKS registers of DATA_W bits each.
- Writes are triggered by a raw push-button strobe, which the block synchronises and edge-detects, so one press equals exactly one write.
- Adds an auto-increment write pointer mode, per-bank valid flags and a saturating write counter.
- Sits between the board switches/button and the LED display path.

Parameters:
- NUM_BANKS, 4, number of storage banks; legal range >= 2, not required to be a power of two.
- DATA_W, 8, width of each bank in bits.
- CNT_W, 8, width of write_count.
- DEBOUNCE_CYCLES, 16, stable cycles required by the debounce filter; used only with DEBOUNCE_EN.
- SEL_W, $clog2(NUM_BANKS), derived localparam; not overridable.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_strobe  in  1  raw asynchronous button level (btnC).
- wr_data  in  DATA_W  data to write.
- wr_sel  in  SEL_W  target bank in direct mode.
- auto_mode  in  1  0 = direct (use wr_sel); 1 = write to wr_ptr, then advance wr_ptr.
- rd_sel  in  SEL_W  bank driven onto rd_data.
- rd_data  out  DATA_W  registered readback of bank[rd_sel].
- bank_valid  out  NUM_BANKS  bit i set once bank i has been written since reset.
- wr_ptr  out  SEL_W  current auto-mode write pointer.
- write_count  out  CNT_W  number of writes since reset, saturating.

Behaviour:
- Reset: synchronous, active-high; one clock only. While reset is high, the following all go to 0:
  - every bank;
  - rd_data, bank_valid, wr_ptr, write_count;
  - both synchroniser flops and the edge-detect history flop.
  - Reset overrides any write in the same cycle.
- Synchroniser: two-flop chain, s1 then s2. The edge-detect flop prev captures s2 on each edge.
- Write pulse: we = s2 & ~prev.
  - Strobe rising before edge 1 gives: s1 high after edge 1; s2 high after edge 2; we high between edge 2 and edge 3; bank updated at edge 3.
  - Write latency is therefore 3 clock edges from the input rise.
  - Holding the strobe high produces no further writes. A new write requires the strobe to go low (s2 = 0 for at least one cycle) and then high again.
- On a cycle with we = 1:
  - The target is wr_sel if auto_mode = 0, or wr_ptr if auto_mode = 1. auto_mode, wr_sel and wr_data are sampled in the we cycle.
  - bank[target] <= wr_data.
  - bank_valid[target] <= 1.
  - write_count increments unless it is already at 2^CNT_W-1, in which case it holds.
  - If auto_mode = 1: wr_ptr <= (wr_ptr == NUM_BANKS-1) ? 0 : wr_ptr+1. The pointer wraps at NUM_BANKS-1 even when NUM_BANKS is not a power of two.
  - If auto_mode = 0: wr_ptr holds.
- Out-of-range wr_sel (>= NUM_BANKS, possible only for non-power-of-two depth): the write is dropped; no bank, bank_valid or write_count change.
- Readback: rd_data <= bank[rd_sel] every cycle, giving 1-cycle latency from rd_sel.
  - Out-of-range rd_sel gives rd_data <= 0.
  - Read of the bank being written in the same cycle returns the old value that cycle and the new value on the following cycle. There is no bypass.
- Switching auto_mode does not modify wr_ptr.
- Reset mid-operation: any in-flight strobe is discarded, because the synchroniser is cleared.
  - A strobe that is still high after reset releases causes one write once it propagates through s1/s2, since prev = 0.

Optional Feature:
- Macro: BANKED_LATCH_FILE_DEBOUNCE_EN.
- Defined:
  - A filter sits between s2 and the edge detector.
  - The debounced level changes only after s2 has held the new value for DEBOUNCE_CYCLES consecutive cycles. A counter of width $clog2(DEBOUNCE_CYCLES+1) resets on any s2 mismatch.
  - Edge detection operates on the debounced level.
  - Write latency is 3 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES produces no write.
  - The counter and debounced level reset to 0.
- Undefined: no filter; behaviour is exactly as in Behaviour, with 3-edge latency.

Test Plan:
- Reset, then rd_sel = 0..3 -> rd_data = 0x00 each time, bank_valid = 4'b0000, write_count = 0, wr_ptr = 0.
- Direct mode, wr_sel = 2, wr_data = 0xA5, strobe high for 10 cycles -> bank2 = 0xA5 at edge 3 exactly, a single write with write_count = 1, bank_valid = 4'b0100; rd_sel = 2 -> rd_data = 0xA5 one cycle later.
- auto_mode = 1, five presses with data 0x11, 0x22, 0x33, 0x44, 0x55 -> banks 0..3 = 0x55, 0x22, 0x33, 0x44; wr_ptr sequence 1, 2, 3, 0, 1; write_count = 5.
- NUM_BANKS = 3, wr_sel = 3 press -> no change and write_count holds; auto mode wraps 2 -> 0.
- CNT_W = 2, five presses -> write_count = 3 and stays at 3.
- With BANKED_LATCH_FILE_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4: a 3-cycle pulse -> no write; a 6-cycle pulse -> one write at edge 7; reset asserted on the we cycle -> bank unchanged, all state 0.
